mem_responder: RTL and testbench

Word-addressed memory responder that sits on the far side of the memory address register (MAR) and memory data register (MDR). It accepts single-word read and write requests through a strobe handshake and inserts a parameterised number of wait states. It performs the access against an internal storage array, returns read data to the MDR, and signals completion with a one-cycle `ready` pulse. It models the datapath's memory so the control unit's memory-wait states can be exercised.

---
 rtl/mem_responder.sv | 125 ++++++++++++
 tb/tb_mem_responder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed memory responder behind the MAR/MDR: a strobe handshake starts one
// read or write, WAIT_STATES idle cycles pass, then the access completes with a ready pulse.
module mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  read,
  input  logic                  write,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ready,
  output logic                  busy,
  output logic                  error
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;
  typedef enum logic       {OP_READ, OP_WRITE}      op_e;

  state_e                  state_q, state_d;
  op_e                     op_q, op_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    error_q, error_d;
  logic                    mem_we;

  // NOTE: the array has no reset branch so it maps onto RAM; it starts zeroed and keeps its contents across clear.
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH] = '{default: '0};

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign error = error_q;

  // NOTE: every next-state value gets a default first so this block never infers a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    ready_d = 1'b0;
    error_d = 1'b0;
    mem_we  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (read && write) begin
          error_d = 1'b1;
        end else if (read) begin
          op_d    = OP_READ;
          addr_d  = addr;
          cnt_d   = WAIT_CNT;
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end else if (write) begin
          op_d    = OP_WRITE;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = WAIT_CNT;
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Access uses only the latched request, never the live bus.
          if (op_q == OP_READ) rdata_d = mem_q[addr_q];
          else                 mem_we  = 1'b1;
          ready_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      op_q    <= OP_READ;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[addr_q] <= wdata_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances (0, 2 and 15 wait states) share
// one stimulus bus; each task targets the instance whose timing it exercises.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        rd    = 1'b0;
  logic        wr    = 1'b0;
  logic [7:0]  addr  = '0;
  logic [31:0] wdata = '0;

  // Index 0: WAIT_STATES=0, 1: WAIT_STATES=2, 2: WAIT_STATES=15.
  logic [31:0] rdata_w [3];
  logic        ready_w [3];
  logic        busy_w  [3];
  logic        error_w [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(0)) u_ws0 (
    .clock(clock), .clear(clear), .addr(addr), .wdata(wdata), .read(rd), .write(wr),
    .rdata(rdata_w[0]), .ready(ready_w[0]), .busy(busy_w[0]), .error(error_w[0]));

  mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(2)) u_ws2 (
    .clock(clock), .clear(clear), .addr(addr), .wdata(wdata), .read(rd), .write(wr),
    .rdata(rdata_w[1]), .ready(ready_w[1]), .busy(busy_w[1]), .error(error_w[1]));

  mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(15)) u_ws15 (
    .clock(clock), .clear(clear), .addr(addr), .wdata(wdata), .read(rd), .write(wr),
    .rdata(rdata_w[2]), .ready(ready_w[2]), .busy(busy_w[2]), .error(error_w[2]));

  // Present a request for exactly one rising edge (edge k); returns 1 ns after edge k.
  task automatic issue(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d);
    @(negedge clock);
    rd = r; wr = w; addr = a; wdata = d;
    @(posedge clock);
    #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  // Count edges after edge k until ready rises on instance idx; lat = -1 if it never does.
  task automatic wait_ready(input int idx, input int limit, output int lat, output logic [31:0] data);
    lat  = -1;
    data = 'x;
    for (int n = 1; n <= limit; n++) begin
      @(posedge clock);
      #1;
      if (ready_w[idx] === 1'b1) begin
        lat  = n;
        data = rdata_w[idx];
        break;
      end
    end
  endtask

  task automatic idle_all();
    logic idle;
    idle = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (busy_w[0] === 1'b0 && busy_w[1] === 1'b0 && busy_w[2] === 1'b0) begin
        idle = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
    end
    n_checks++;
    if (idle !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_timeout: busy=%b%b%b required 000", busy_w[0], busy_w[1], busy_w[2]);
    end
  endtask

  task automatic test_reset();
    int          lat;
    logic [31:0] d;
    #1 clear = 1'b1;
    #2;
    n_checks += 4;
    if (rdata_w[1] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata_w[1]); end
    if (ready_w[1] !== 1'b0)  begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready_w[1]); end
    if (busy_w[1]  !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_w[1]); end
    if (error_w[1] !== 1'b0)  begin n_fail++; $display("FAIL reset_error: got %b want 0", error_w[1]); end
    @(negedge clock);
    clear = 1'b0;

    // Seed rdata with a nonzero word so the asynchronous clear below is visible.
    issue(1'b0, 1'b1, 8'h20, 32'hA5A5A5A5);
    wait_ready(1, 10, lat, d);
    idle_all();
    issue(1'b1, 1'b0, 8'h20, 32'h0);
    wait_ready(1, 10, lat, d);
    n_checks++;
    if (d !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL seed_read: got %h want a5a5a5a5", d); end
    idle_all();

    issue(1'b1, 1'b0, 8'h20, 32'h0);
    @(negedge clock);
    #2 clear = 1'b1;
    #1;
    n_checks += 4;
    if (rdata_w[1] !== 32'h0) begin n_fail++; $display("FAIL async_clear_rdata: got %h want 0", rdata_w[1]); end
    if (ready_w[1] !== 1'b0)  begin n_fail++; $display("FAIL async_clear_ready: got %b want 0", ready_w[1]); end
    if (busy_w[1]  !== 1'b0)  begin n_fail++; $display("FAIL async_clear_busy: got %b want 0", busy_w[1]); end
    if (busy_w[2]  !== 1'b0)  begin n_fail++; $display("FAIL async_clear_busy15: got %b want 0", busy_w[2]); end
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic test_write_read();
    logic [5:0]  rdy_pat, bsy_pat;
    int          lat;
    logic [31:0] d;
    idle_all();
    issue(1'b0, 1'b1, 8'h12, 32'hDEADBEEF);
    rdy_pat = '0; bsy_pat = '0;
    rdy_pat[0] = ready_w[1]; bsy_pat[0] = busy_w[1];
    for (int n = 1; n < 6; n++) begin
      @(posedge clock);
      #1;
      rdy_pat[n] = ready_w[1];
      bsy_pat[n] = busy_w[1];
    end
    // ready only after edge k+3; busy after edges k..k+3.
    n_checks += 2;
    if (rdy_pat !== 6'b001000) begin n_fail++; $display("FAIL write_ready_timing: got %b want 001000", rdy_pat); end
    if (bsy_pat !== 6'b001111) begin n_fail++; $display("FAIL write_busy_timing: got %b want 001111", bsy_pat); end

    idle_all();
    issue(1'b1, 1'b0, 8'h12, 32'h0);
    wait_ready(1, 10, lat, d);
    n_checks += 2;
    if (lat !== 3)          begin n_fail++; $display("FAIL read_latency: got %0d want 3", lat); end
    if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data: got %h want deadbeef", d); end
    @(posedge clock);
    #1;
    n_checks += 2;
    if (ready_w[1] !== 1'b0)        begin n_fail++; $display("FAIL ready_one_cycle: got %b want 0", ready_w[1]); end
    if (rdata_w[1] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rdata_hold: got %h want deadbeef", rdata_w[1]); end
  endtask

  task automatic test_latency();
    int          lat;
    logic [31:0] d;
    idle_all();
    issue(1'b1, 1'b0, 8'hFF, 32'h0);
    wait_ready(0, 5, lat, d);
    n_checks += 2;
    if (lat !== 1)   begin n_fail++; $display("FAIL ws0_latency: got %0d want 1", lat); end
    if (d !== 32'h0) begin n_fail++; $display("FAIL ws0_data: got %h want 0", d); end

    idle_all();
    issue(1'b1, 1'b0, 8'hFF, 32'h0);
    wait_ready(2, 30, lat, d);
    n_checks += 2;
    if (lat !== 16)  begin n_fail++; $display("FAIL ws15_latency: got %0d want 16", lat); end
    if (d !== 32'h0) begin n_fail++; $display("FAIL ws15_data: got %h want 0", d); end
  endtask

  task automatic test_input_stability();
    logic [3:0]  rdy_pat;
    int          lat;
    logic [31:0] d;
    idle_all();
    issue(1'b0, 1'b1, 8'h12, 32'hCAFEF00D);
    addr = 8'h34; wdata = 32'h1; rd = 1'b1;
    rdy_pat = '0;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clock);
      #1;
      if (n == 2) rd = 1'b0;
      rdy_pat[n-1] = ready_w[1];
    end
    n_checks++;
    if (rdy_pat !== 4'b0100) begin n_fail++; $display("FAIL stable_ready_timing: got %b want 0100", rdy_pat); end
    @(posedge clock);
    #1;
    n_checks++;
    if (busy_w[1] !== 1'b0) begin n_fail++; $display("FAIL stable_no_restart: got busy %b want 0", busy_w[1]); end

    idle_all();
    issue(1'b1, 1'b0, 8'h12, 32'h0);
    wait_ready(1, 10, lat, d);
    n_checks++;
    if (d !== 32'hCAFEF00D) begin n_fail++; $display("FAIL stable_mem12: got %h want cafef00d", d); end
    idle_all();
    issue(1'b1, 1'b0, 8'h34, 32'h0);
    wait_ready(1, 10, lat, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL stable_mem34: got %h want 0", d); end
  endtask

  task automatic test_conflict();
    logic        saw_ready, saw_busy;
    int          lat;
    logic [31:0] d;
    idle_all();
    @(negedge clock);
    rd = 1'b1; wr = 1'b1; addr = 8'h12; wdata = 32'h11111111;
    @(posedge clock);
    #1;
    n_checks += 2;
    if (error_w[1] !== 1'b1) begin n_fail++; $display("FAIL conflict_error: got %b want 1", error_w[1]); end
    if (busy_w[1]  !== 1'b0) begin n_fail++; $display("FAIL conflict_busy: got %b want 0", busy_w[1]); end
    rd = 1'b0; wr = 1'b0;
    saw_ready = 1'b0; saw_busy = 1'b0;
    @(posedge clock);
    #1;
    n_checks++;
    if (error_w[1] !== 1'b0) begin n_fail++; $display("FAIL conflict_error_pulse: got %b want 0", error_w[1]); end
    for (int n = 0; n < 6; n++) begin
      saw_ready |= ready_w[1];
      saw_busy  |= busy_w[1];
      @(posedge clock);
      #1;
    end
    n_checks += 2;
    if (saw_ready !== 1'b0) begin n_fail++; $display("FAIL conflict_no_ready: got %b want 0", saw_ready); end
    if (saw_busy  !== 1'b0) begin n_fail++; $display("FAIL conflict_no_busy: got %b want 0", saw_busy); end
    issue(1'b1, 1'b0, 8'h12, 32'h0);
    wait_ready(1, 10, lat, d);
    n_checks++;
    if (d !== 32'hCAFEF00D) begin n_fail++; $display("FAIL conflict_mem: got %h want cafef00d", d); end
  endtask

  task automatic test_abort();
    logic        saw_ready;
    int          lat;
    logic [31:0] d;
    idle_all();
    issue(1'b0, 1'b1, 8'h07, 32'h55AA55AA);
    @(posedge clock);
    #2 clear = 1'b1;
    #1;
    n_checks++;
    if (busy_w[1] !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy_w[1]); end
    @(negedge clock);
    clear = 1'b0;
    saw_ready = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clock);
      #1;
      saw_ready |= ready_w[1];
    end
    n_checks++;
    if (saw_ready !== 1'b0) begin n_fail++; $display("FAIL abort_no_ready: got %b want 0", saw_ready); end

    issue(1'b1, 1'b0, 8'h07, 32'h0);
    wait_ready(1, 10, lat, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL abort_mem_ws2: got %h want 0", d); end
    idle_all();
    issue(1'b1, 1'b0, 8'h07, 32'h0);
    wait_ready(2, 30, lat, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL abort_mem_ws15: got %h want 0", d); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] rdy_pat, bsy_pat;
    idle_all();
    @(negedge clock);
    rd = 1'b1; addr = 8'h12;
    rdy_pat = '0; bsy_pat = '0;
    for (int n = 0; n < 11; n++) begin
      @(posedge clock);
      #1;
      rdy_pat[n] = ready_w[1];
      bsy_pat[n] = busy_w[1];
    end
    rd = 1'b0;
    // Held read re-accepted at edges k, k+5, k+10.
    n_checks += 3;
    if (rdy_pat !== 11'b00100001000) begin n_fail++; $display("FAIL b2b_ready: got %b want 00100001000", rdy_pat); end
    if (bsy_pat !== 11'b10111101111) begin n_fail++; $display("FAIL b2b_busy: got %b want 10111101111", bsy_pat); end
    if (rdata_w[1] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_data: got %h want cafef00d", rdata_w[1]); end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_latency();
    test_input_stability();
    test_conflict();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
